fxp_multiplier: RTL and testbench

- Pipelined signed fixed-point multiplier with a parameterised binary point on each input and on the output.
- Computes m = a × b with round-to-nearest rescaling to the output format, then saturation or wrap to the output width.
- Generic arithmetic leaf used by DSP datapaths, e.g. lifting or wavelet stages.
- A valid flag travels alongside the data; there is no backpressure.

---
 rtl/fxp_pkg.sv | 40 ++++
 rtl/fxp_round_sat.sv | 35 +++
 rtl/fxp_multiplier.sv | 86 ++++++++
 tb/tb_fxp_multiplier.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: rescale with round-half-up and clamp to a signed width.
// Values travel in a wide signed container so any supported product fits without loss.
package fxp_pkg;

    localparam int unsigned FxpMaxWidth = 128;

    typedef logic signed [FxpMaxWidth-1:0] fxp_wide_t;

    // shift > 0 drops fractional bits with ties toward +inf; shift < 0 appends zero bits.
    function automatic fxp_wide_t fxp_shift_round(input fxp_wide_t value, input int shift);
        fxp_wide_t half;
        fxp_wide_t res;
        if (shift > 0) begin
            half = fxp_wide_t'(1) <<< (shift - 1);
            res  = (value + half) >>> shift;
        end else if (shift == 0) begin
            res = value;
        end else begin
            res = value <<< (-shift);
        end
        return res;
    endfunction

    function automatic fxp_wide_t fxp_sat(input fxp_wide_t value, input int unsigned width);
        fxp_wide_t max_v;
        fxp_wide_t min_v;
        fxp_wide_t res;
        max_v = (fxp_wide_t'(1) <<< (width - 1)) - fxp_wide_t'(1);
        min_v = -max_v - fxp_wide_t'(1);
        if (value > max_v) begin
            res = max_v;
        end else if (value < min_v) begin
            res = min_v;
        end else begin
            res = value;
        end
        return res;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rescale of a signed fixed-point value to a new format, then clamp or wrap.
// MULT_SAT_EN selects clamping and adds the sat flag; otherwise the result wraps.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int InWidth  = 32,
    parameter int InPoint  = 20,
    parameter int OutWidth = 16,
    parameter int OutPoint = 10
) (
    input  logic signed [InWidth-1:0]  value,
    output logic signed [OutWidth-1:0] result
`ifdef MULT_SAT_EN
    ,
    output logic                       sat
`endif
);

    localparam int Shift = InPoint - OutPoint;

    fxp_wide_t scaled;
    fxp_wide_t limited;

    always_comb begin
        scaled  = fxp_shift_round(fxp_wide_t'(value), Shift);
`ifdef MULT_SAT_EN
        limited = fxp_sat(scaled, OutWidth);
        sat     = (limited != scaled);
`else
        limited = scaled;
`endif
        result  = OutWidth'(limited);
    end

endmodule

// File: rtl/fxp_multiplier.sv
// Two-stage signed fixed-point multiplier: full product register, then rescale/limit register.
// Define MULT_SAT_EN for saturation and the sat_o flag; default build wraps.
module fxp_multiplier
    import fxp_pkg::*;
#(
    parameter int AWidth   = 16,
    parameter int APoint   = 12,
    parameter int BWidth   = 16,
    parameter int BPoint   = 8,
    parameter int OutWidth = 16,
    parameter int OutPoint = 10
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic signed [AWidth-1:0]   a_i,
    input  logic signed [BWidth-1:0]   b_i,
    output logic                       valid_o,
    output logic signed [OutWidth-1:0] m_o
`ifdef MULT_SAT_EN
    ,
    output logic                       sat_o
`endif
);

    localparam int ProdWidth = AWidth + BWidth;
    localparam int ProdPoint = APoint + BPoint;
    localparam int UpShift   = (OutPoint > ProdPoint) ? (OutPoint - ProdPoint) : 0;

    if (AWidth < 2 || BWidth < 2 || OutWidth < 2 ||
        APoint < 0 || BPoint < 0 || OutPoint < 0) begin : g_bad_params
        $error("fxp_multiplier: widths must be >= 2 and points >= 0");
    end

    if (ProdWidth + UpShift + 1 > int'(FxpMaxWidth) || OutWidth > int'(FxpMaxWidth)) begin : g_too_wide
        $error("fxp_multiplier: configuration exceeds the fxp_pkg container width");
    end

    logic                        valid_q;
    logic signed [ProdWidth-1:0] prod_q;
    logic signed [OutWidth-1:0]  m_next;
`ifdef MULT_SAT_EN
    logic                        sat_next;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            prod_q  <= '0;
        end else begin
            valid_q <= valid_i;
            prod_q  <= ProdWidth'(a_i) * ProdWidth'(b_i);
        end
    end

    fxp_round_sat #(
        .InWidth  (ProdWidth),
        .InPoint  (ProdPoint),
        .OutWidth (OutWidth),
        .OutPoint (OutPoint)
    ) u_round_sat (
        .value  (prod_q),
        .result (m_next)
`ifdef MULT_SAT_EN
        ,
        .sat    (sat_next)
`endif
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_o <= 1'b0;
            m_o     <= '0;
`ifdef MULT_SAT_EN
            sat_o   <= 1'b0;
`endif
        end else begin
            valid_o <= valid_q;
            m_o     <= m_next;
`ifdef MULT_SAT_EN
            sat_o   <= sat_next;
`endif
        end
    end

endmodule

// File: tb/tb_fxp_multiplier.sv
// Self-checking bench for fxp_multiplier: directed cases plus random operands against an arithmetic model.
// Honours MULT_SAT_EN the same way the design does.
module tb_fxp_multiplier;

    localparam int AW = 16;
    localparam int AP = 12;
    localparam int BW = 16;
    localparam int BP = 8;
    localparam int OW = 16;
    localparam int OP = 10;
    localparam int S  = AP + BP - OP;
    localparam int DivBits = (S > 0) ? S : 0;
    localparam int MulBits = (S < 0) ? -S : 0;

`ifdef MULT_SAT_EN
    localparam longint OvfLit = 32767;
`else
    localparam longint OvfLit = -4096;
`endif

    typedef struct {
        bit     chk_m;
        bit     valid;
        longint m;
        bit     sat;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 valid_i = 1'b0;
    logic signed [AW-1:0] a_i = '0;
    logic signed [BW-1:0] b_i = '0;
    logic                 valid_o;
    logic signed [OW-1:0] m_o;
`ifdef MULT_SAT_EN
    logic                 sat_o;
`endif

    exp_t        pend[$];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    fxp_multiplier #(
        .AWidth   (AW),
        .APoint   (AP),
        .BWidth   (BW),
        .BPoint   (BP),
        .OutWidth (OW),
        .OutPoint (OP)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .m_o     (m_o)
`ifdef MULT_SAT_EN
        ,
        .sat_o   (sat_o)
`endif
    );

    // Exact rational product scaled to the output LSB, floor(x + 1/2), then clamp or modulo.
    function automatic void ref_model(input longint a, input longint b,
                                      output longint m, output bit sat);
        longint num, d, r, hi, lo, span;
        d   = longint'(1) << DivBits;
        num = a * b * (longint'(1) << MulBits) + d / 2;
        r   = num / d;
        if ((num % d) != 0 && num < 0) r = r - 1;
        hi   = (longint'(1) << (OW - 1)) - 1;
        lo   = -hi - 1;
        span = longint'(1) << OW;
        sat  = 1'b0;
`ifdef MULT_SAT_EN
        if (r > hi) begin
            m = hi; sat = 1'b1;
        end else if (r < lo) begin
            m = lo; sat = 1'b1;
        end else begin
            m = r;
        end
`else
        m = ((r % span) + span) % span;
        if (m > hi) m = m - span;
`endif
    endfunction

    task automatic step(input bit rst, input bit v, input longint a, input longint b,
                        input bit use_lit, input longint lit, input string tag);
        exp_t cur;
        exp_t nxt;
        rst_i   = rst;
        valid_i = v;
        a_i     = a[AW-1:0];
        b_i     = b[BW-1:0];
        nxt.valid = v;
        nxt.chk_m = v;
        ref_model(longint'(a_i), longint'(b_i), nxt.m, nxt.sat);
        if (use_lit) nxt.m = lit;
        @(posedge clk);
        #1;
        if (rst) begin
            cur = '{chk_m: 1'b1, valid: 1'b0, m: 0, sat: 1'b0};
            pend.delete();
            pend.push_back(cur);
        end else begin
            cur = pend.pop_front();
            pend.push_back(nxt);
        end
        n_tests++;
        assert (valid_o === cur.valid)
        else begin
            n_fail++;
            $error("FAIL %s valid_o: got %b expected %b", tag, valid_o, cur.valid);
        end
        if (cur.chk_m) begin
            n_tests++;
            assert (longint'(m_o) === cur.m)
            else begin
                n_fail++;
                $error("FAIL %s m_o: got %0d expected %0d", tag, m_o, cur.m);
            end
`ifdef MULT_SAT_EN
            n_tests++;
            assert (sat_o === cur.sat)
            else begin
                n_fail++;
                $error("FAIL %s sat_o: got %b expected %b", tag, sat_o, cur.sat);
            end
`endif
        end
    endtask

    initial begin
        longint ra, rb;

        step(1, 0, 0, 0, 0, 0, "reset");
        step(1, 0, 0, 0, 0, 0, "reset");
        step(1, 1, 6144, 512, 0, 0, "reset_hold");

        step(0, 1, 6144, 512, 1, 3072, "mul_1p5x2");
        step(0, 1, 1024, -1792, 1, -1792, "mul_neg");
        step(0, 1, -409, -1049, 1, 419, "round_up");
        step(0, 1, 2, 256, 1, 1, "tie_pos");
        step(0, 1, -2, 256, 1, 0, "tie_neg");
        step(0, 1, 28672, 25600, 1, OvfLit, "overflow_pos");
        step(0, 1, -28672, 25600, 0, 0, "overflow_neg");
        step(0, 1, -32768, -32768, 0, 0, "min_x_min");
        step(0, 0, 0, 0, 0, 0, "idle");
        step(0, 0, 0, 0, 0, 0, "idle");

        // Five back-to-back operations, then a reset pulse while two are still in the pipe.
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1000 + i * 37, 300 - i * 11, 0, 0, "b2b");
        end
        step(1, 0, 0, 0, 0, 0, "flush_rst");
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 0, "post_flush");
        end

        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 1) == 1) ? longint'($urandom)
                                            : longint'($urandom_range(0, 4095)) - 2048;
            rb = ($urandom_range(0, 1) == 1) ? longint'($urandom)
                                            : longint'($urandom_range(0, 4095)) - 2048;
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, ra, rb, 0, 0, "random");
        end
        step(0, 0, 0, 0, 0, 0, "drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
